// File: rtl/imem_loader.sv
// imem_loader: boot-loads a word RAM from a byte stream, then serves core instruction fetches
module imem_loader #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LEN_W       = 16,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             ld_valid,
  input  logic [7:0]       ld_data,
  output logic             ld_ready,
  input  logic [31:0]      imem_addr,
  output logic [31:0]      imem_out,
  output logic             cpu_rst,
  output logic             load_done,
  output logic             fetch_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int LW = (LEN_W > AW) ? LEN_W : AW + 1;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [LW-1:0] len_q, len_d, loaded_q, loaded_d, len_min;
  logic [23:0] buf_q, buf_d;
  logic done_q, done_d, we, ok;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  assign len_min = (LW'(load_len) > LW'(DEPTH_WORDS)) ? LW'(DEPTH_WORDS) : LW'(load_len);
  assign idx = imem_addr[AW+1:2];
  assign ok = (imem_addr[1:0] == 2'b00) && ((imem_addr >> (AW + 2)) == 32'd0) &&
              ({{(LW-AW){1'b0}}, idx} < loaded_q);
  assign imem_out = ok ? mem[idx] : NOP_WORD;
  assign fetch_err = (state_q == RUN) && !ok;
  assign ld_ready = state_q == LOAD;
  assign cpu_rst = state_q != RUN;
  assign load_done = done_q;
  // next-state: start/restart a load, assemble bytes into words, finish into RUN
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    len_d = len_q;
    loaded_d = loaded_q;
    buf_d = buf_q;
    done_d = 1'b0;
    we = 1'b0;
    if (load_start && state_q != LOAD) begin
      len_d = len_min;
      loaded_d = '0;
      cnt_d = 2'd0;
      state_d = (len_min == '0) ? RUN : LOAD;
      done_d = len_min == '0;
    end else if (state_q == LOAD && ld_valid) begin
      cnt_d = cnt_q + 2'd1;
      if (cnt_q != 2'd3) buf_d[8*cnt_q +: 8] = ld_data;
      else begin
        we = 1'b1;
        loaded_d = loaded_q + 1'b1;
        state_d = (loaded_q + 1'b1 == len_q) ? RUN : LOAD;
        done_d = loaded_q + 1'b1 == len_q;
      end
    end
  end
  // control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 2'd0;
      len_q <= '0;
      loaded_q <= '0;
      buf_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      loaded_q <= loaded_d;
      buf_q <= buf_d;
      done_q <= done_d;
    end
  end
  // program RAM, unreset and masked by loaded_q
  always_ff @(posedge clk) begin
    if (we && !rst) mem[loaded_q[AW-1:0]] <= {ld_data, buf_q};
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of boot loading, reset abort, reload and fetch masking
module tb_imem_loader;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b1, load_start = 1'b0, ld_valid = 1'b0;
  logic [15:0] load_len = 16'd0;
  logic [7:0] ld_data = 8'h00;
  logic [31:0] imem_addr = 32'd0;
  logic ld_ready, cpu_rst, load_done, fetch_err;
  logic [31:0] imem_out;
  logic [7:0] prog [12] = '{8'h93, 8'h00, 8'h10, 8'h00, 8'he3, 8'h0e, 8'h00, 8'hfe,
                            8'h93, 8'h00, 8'h20, 8'h00};
  int errs = 0, checks = 0;
  imem_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .imem_addr(imem_addr), .imem_out(imem_out), .cpu_rst(cpu_rst),
    .load_done(load_done), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] exp, input logic err);
    imem_addr = a;
    #1;
    chk({tag, "_out"}, imem_out, exp);
    chk({tag, "_err"}, {31'd0, fetch_err}, {31'd0, err});
  endtask
  task automatic start(input logic [15:0] len);
    load_start = 1'b1;
    load_len = len;
    tick();
    load_start = 1'b0;
    chk("start_rdy", {31'd0, ld_ready}, {31'd0, len != 16'd0});
    chk("start_done", {31'd0, load_done}, {31'd0, len == 16'd0});
    chk("start_cpurst", {31'd0, cpu_rst}, {31'd0, len != 16'd0});
  endtask
  task automatic send(input int first, input int nb, input bit gap, input bit finish);
    for (int i = 0; i < nb; i++) begin
      chk("ld_cpurst", {31'd0, cpu_rst}, 32'd1);
      chk("ld_rdy", {31'd0, ld_ready}, 32'd1);
      chk("ld_done", {31'd0, load_done}, 32'd0);
      ld_valid = 1'b1;
      ld_data = prog[first+i];
      tick();
      ld_valid = 1'b0;
      if (gap && i < nb - 1) tick();
    end
    if (finish) begin
      chk("fin_done", {31'd0, load_done}, 32'd1);
      chk("fin_cpurst", {31'd0, cpu_rst}, 32'd0);
      chk("fin_rdy", {31'd0, ld_ready}, 32'd0);
    end
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_cpurst", {31'd0, cpu_rst}, 32'd1);
    chk("rst_rdy", {31'd0, ld_ready}, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    fetch("rst_a0", 32'd0, NOP, 1'b0);
    start(16'd2);
    send(0, 8, 1'b0, 1'b1);
    tick();
    chk("pulse_end", {31'd0, load_done}, 32'd0);
    chk("run_cpurst", {31'd0, cpu_rst}, 32'd0);
    fetch("l1_a0", 32'd0, 32'h0010_0093, 1'b0);
    fetch("l1_a4", 32'd4, 32'hfe00_0ee3, 1'b0);
    fetch("l1_a8", 32'd8, NOP, 1'b1);
    fetch("mis_a2", 32'd2, NOP, 1'b1);
    fetch("hi_a1000", 32'h0000_1000, NOP, 1'b1);
    start(16'd2);
    fetch("reload_mask", 32'd0, NOP, 1'b0);
    send(0, 8, 1'b1, 1'b1);
    fetch("l2_a0", 32'd0, 32'h0010_0093, 1'b0);
    fetch("l2_a4", 32'd4, 32'hfe00_0ee3, 1'b0);
    start(16'd2);
    send(0, 5, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_cpurst", {31'd0, cpu_rst}, 32'd1);
    chk("abort_rdy", {31'd0, ld_ready}, 32'd0);
    chk("abort_done", {31'd0, load_done}, 32'd0);
    fetch("abort_a0", 32'd0, NOP, 1'b0);
    tick();
    chk("idle_hold", {31'd0, cpu_rst}, 32'd1);
    start(16'd2);
    send(0, 8, 1'b0, 1'b1);
    tick();
    start(16'd1);
    send(8, 4, 1'b0, 1'b1);
    fetch("l3_a0", 32'd0, 32'h0020_0093, 1'b0);
    fetch("l3_a4", 32'd4, NOP, 1'b1);
    tick();
    start(16'd0);
    fetch("z_a0", 32'd0, NOP, 1'b1);
    fetch("z_a4", 32'd4, NOP, 1'b1);
    tick();
    chk("z_pulse_end", {31'd0, load_done}, 32'd0);
    chk("z_rdy", {31'd0, ld_ready}, 32'd0);
    chk("z_cpurst", {31'd0, cpu_rst}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-memory responder for the rv32 core. It sits on the other side of the core's fetch port: the core drives imem_addr, and this block answers with imem_out.
- Before the core runs, a byte-stream boot interface loads the program into a word RAM. The block holds the core in reset while loading and releases it once the load completes.
- Replaces the testbench-driven imem_out in system-level benches.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit instruction words stored (power of 2).
- LEN_W, 16, width of the load-length field in words.
- NOP_WORD, 32'h0000_0013, value returned for unloaded, out-of-range or misaligned fetches (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- load_start  in  1  one-cycle request to begin a load; sampled in IDLE and RUN.
- load_len  in  LEN_W  program length in words; sampled with load_start.
- ld_valid  in  1  boot byte valid.
- ld_data  in  8  boot byte.
- ld_ready  out  1  block accepts a byte this cycle.
- imem_addr  in  32  core fetch byte address.
- imem_out  out  32  instruction word; combinational read of imem_addr.
- cpu_rst  out  1  reset to the core; high while not in RUN.
- load_done  out  1  one-cycle pulse on entry to RUN.
- fetch_err  out  1  combinational; high when in RUN and imem_addr[1:0]!=0 or the word index >= loaded length.

Behaviour:
- Reset values:
  - state=IDLE, cpu_rst=1, ld_ready=0, load_done=0.
  - Byte counter=0, loaded_len=0.
  - RAM contents are not reset. They are masked by loaded_len.
- States:
  - IDLE, LOAD, RUN.
  - A rst asserted in any state, including mid-load, returns to IDLE with loaded_len=0. Any partial word is discarded.
- IDLE:
  - load_start=1 latches len = min(load_len, DEPTH_WORDS) and clears the byte counter.
  - If len==0, go to RUN. Otherwise go to LOAD.
  - loaded_len is cleared to 0 on every load_start.
- LOAD:
  - ld_ready=1 (registered, high from the first LOAD cycle).
  - A byte is accepted on any edge where ld_valid&&ld_ready. Gaps with ld_valid=0 are allowed and hold all state.
  - Byte k goes to bits [8*(k%4)+7 : 8*(k%4)] of word k/4 (little-endian).
  - The RAM word is written on the edge accepting byte k%4==3, and loaded_len increments on that same edge.
  - On the edge accepting the final byte (k==4*len-1), the next state is RUN and ld_ready drops to 0 in the same cycle RUN is entered.
  - load_start is ignored while in LOAD.
- RUN:
  - cpu_rst=0 from the first RUN cycle. load_done=1 for that cycle only.
  - load_start=1 re-enters LOAD, or RUN again if len==0. cpu_rst=1 from the next cycle, and load_done pulses again on return to RUN.
- Fetch path (all states, combinational):
  - idx = imem_addr[log2(DEPTH)+1:2]. imem_addr bits above that range must be 0.
  - imem_out = RAM[idx] if aligned, in range and idx < loaded_len. Otherwise imem_out = NOP_WORD.
  - In-range means high bits are 0 and idx < DEPTH_WORDS.
- Simultaneous events:
  - rst has priority over load_start and ld_valid.
  - A fetch of the word being written in the same cycle returns the old value or NOP. The new value is visible the next cycle.

Test Plan:
- Reset, then load_start with load_len=2 and bytes 93,00,10,00,e3,0e,00,fe back-to-back:
  - load_done pulses 9 cycles after load_start (1 cycle to enter LOAD plus 8 accept edges).
  - cpu_rst falls on the same cycle.
  - imem_addr=0 gives 32'h0010_0093, imem_addr=4 gives 32'hfe00_0ee3, imem_addr=8 gives 32'h0000_0013 with fetch_err=1.
- Same load with ld_valid toggling 1,0,1,0…:
  - Identical memory image and words.
  - cpu_rst held at 1 until the eighth byte is accepted.
  - ld_ready stays 1 throughout LOAD.
- rst pulse after 5 of 8 bytes:
  - State IDLE, cpu_rst=1, ld_ready=0.
  - imem_addr=0 gives 32'h0000_0013, because loaded_len=0.
- In RUN, imem_addr=32'h0000_0002 → imem_out=32'h0000_0013, fetch_err=1. imem_addr=32'h0000_1000 (above DEPTH 256) → NOP, fetch_err=1.
- In RUN, load_start with load_len=1 and bytes 93,00,20,00:
  - cpu_rst rises the next cycle.
  - After load_done, addr 0 gives 32'h0020_0093 and addr 4 gives NOP, because the old word 1 is masked.
- load_start with load_len=0 → RUN the next cycle with load_done=1, ld_ready never high, all fetches NOP.
